mat_alu_seq: RTL and testbench

//   Multi-cycle, parametrised matrix ALU: NxN matrices of W-bit unsigned elements.

---
 rtl/mat_pkg.sv | 25 ++
 rtl/mat_dot.sv | 26 ++
 rtl/mat_alu_seq.sv | 182 ++++++++++++++++++
 tb/tb_mat_alu_seq.sv | 338 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mat_pkg.sv
// Shared definitions for the sequential matrix ALU.
//   - Opcode encodings (OP_NOP .. OP_MTRANS); 6..F are unsupported.
//   - FSM state type.
//   - mat_idx(): bit offset of element (r,c) in a row-major packed NxN matrix.
package mat_pkg;

    localparam logic [3:0] OP_NOP    = 4'h0;
    localparam logic [3:0] OP_MMULT  = 4'h1;
    localparam logic [3:0] OP_MSCALE = 4'h2;
    localparam logic [3:0] OP_MSUB   = 4'h3;
    localparam logic [3:0] OP_MADD   = 4'h4;
    localparam logic [3:0] OP_MTRANS = 4'h5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Element (r,c) lives at bits [(r*n+c)*w +: w].
    function automatic int mat_idx(input int r, input int c, input int n, input int w);
        return (r * n + c) * w;
    endfunction

endpackage

// File: rtl/mat_dot.sv
// Combinational N-term dot product of one matrix row and one matrix column.
// Ports:
//   row  in  N*W  packed row elements, element k at [k*W +: W]
//   col  in  N*W  packed column elements, element k at [k*W +: W]
//   dot  out W    sum of row[k]*col[k], truncated to W bits
module mat_dot
    import mat_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic [N*W-1:0] row,
    input  logic [N*W-1:0] col,
    output logic [W-1:0]   dot
);

    // Products and the running sum are kept at W bits: only the low W bits
    // of the final sum are wanted, and those depend only on low W bits.
    always_comb begin
        dot = '0;
        for (int k = 0; k < N; k++) begin
            dot = dot + row[mat_idx(0, k, N, W) +: W] * col[mat_idx(0, k, N, W) +: W];
        end
    end

endmodule

// File: rtl/mat_alu_seq.sv
// Multi-cycle NxN matrix ALU (W-bit unsigned elements, modulo 2^W arithmetic).
// Operations: NOP, MMULT, MSCALE, MSUB, MADD, MTRANS behind a start/done handshake.
// Ports:
//   clk_i           in   1     clock, rising edge
//   rst_i           in   1     synchronous reset, active high
//   start_i         in   1     request, accepted only while ready_o=1
//   opcode_i        in   4     operation, sampled with start_i
//   matrix_a_i      in   MW    operand A, sampled with start_i
//   matrix_b_i      in   MW    operand B, sampled with start_i
//   ready_o         out  1     idle, can accept start_i
//   done_o          out  1     one-cycle pulse, result valid from this cycle
//   err_o           out  1     with done_o: unsupported opcode
//   matrix_result_o out  MW    result, holds until the next done_o
// MMULT computes one element per cycle through a single shared dot-product
// unit, so the result register shows partial values until done_o.
module mat_alu_seq
    import mat_pkg::*;
#(
    parameter int N = 4,
    parameter int W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [3:0]       opcode_i,
    input  logic [N*N*W-1:0] matrix_a_i,
    input  logic [N*N*W-1:0] matrix_b_i,
    output logic             ready_o,
    output logic             done_o,
    output logic             err_o,
    output logic [N*N*W-1:0] matrix_result_o
);

    localparam int MW = N * N * W;
    localparam int IW = $clog2(N * N);
    localparam logic [IW-1:0] IDX_LAST = IW'(N * N - 1);

    state_t          state_reg;
    logic [3:0]      op_reg;
    logic [MW-1:0]   a_reg;
    logic [MW-1:0]   b_reg;
    logic [MW-1:0]   result_reg;
    logic [IW-1:0]   idx_reg;
    logic            ready_reg;
    logic            done_reg;
    logic            err_reg;

    // Element-wise results, one lane per matrix element.
    logic [MW-1:0]   add_res;
    logic [MW-1:0]   sub_res;
    logic [MW-1:0]   scale_res;
    logic [MW-1:0]   trans_res;

    // Row/column feeding the shared dot-product unit for element idx_reg.
    int              r_sel;
    int              c_sel;
    logic [N*W-1:0]  row_vec;
    logic [N*W-1:0]  col_vec;
    logic [W-1:0]    dot_val;

    assign r_sel = int'(idx_reg) / N;
    assign c_sel = int'(idx_reg) % N;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_sel
            assign row_vec[gi*W +: W] = a_reg[mat_idx(r_sel, gi, N, W) +: W];
            assign col_vec[gi*W +: W] = b_reg[mat_idx(gi, c_sel, N, W) +: W];
        end
    endgenerate

    mat_dot #(
        .N (N),
        .W (W)
    ) u_dot (
        .row (row_vec),
        .col (col_vec),
        .dot (dot_val)
    );

    generate
        for (genvar gi = 0; gi < N * N; gi++) begin : g_lane
            localparam int R = gi / N;
            localparam int C = gi % N;
            assign add_res[gi*W +: W]   = a_reg[gi*W +: W] + b_reg[gi*W +: W];
            assign sub_res[gi*W +: W]   = a_reg[gi*W +: W] - b_reg[gi*W +: W];
            // Scalar is B[0][0].
            assign scale_res[gi*W +: W] = a_reg[gi*W +: W] * b_reg[W-1:0];
            assign trans_res[gi*W +: W] = a_reg[mat_idx(C, R, N, W) +: W];
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg  <= ST_IDLE;
            op_reg     <= OP_NOP;
            a_reg      <= '0;
            b_reg      <= '0;
            result_reg <= '0;
            idx_reg    <= '0;
            ready_reg  <= 1'b1;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    done_reg <= 1'b0;
                    err_reg  <= 1'b0;
                    if (start_i) begin
                        op_reg    <= opcode_i;
                        a_reg     <= matrix_a_i;
                        b_reg     <= matrix_b_i;
                        idx_reg   <= '0;
                        ready_reg <= 1'b0;
                        state_reg <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    case (op_reg)
                        OP_MMULT: begin
                            result_reg[int'(idx_reg)*W +: W] <= dot_val;
                            if (idx_reg == IDX_LAST) begin
                                done_reg  <= 1'b1;
                                state_reg <= ST_DONE;
                            end else begin
                                idx_reg <= idx_reg + IW'(1);
                            end
                        end
                        OP_MADD: begin
                            result_reg <= add_res;
                            done_reg   <= 1'b1;
                            state_reg  <= ST_DONE;
                        end
                        OP_MSUB: begin
                            result_reg <= sub_res;
                            done_reg   <= 1'b1;
                            state_reg  <= ST_DONE;
                        end
                        OP_MSCALE: begin
                            result_reg <= scale_res;
                            done_reg   <= 1'b1;
                            state_reg  <= ST_DONE;
                        end
                        OP_MTRANS: begin
                            result_reg <= trans_res;
                            done_reg   <= 1'b1;
                            state_reg  <= ST_DONE;
                        end
                        OP_NOP: begin
                            done_reg  <= 1'b1;
                            state_reg <= ST_DONE;
                        end
                        default: begin
                            result_reg <= '0;
                            err_reg    <= 1'b1;
                            done_reg   <= 1'b1;
                            state_reg  <= ST_DONE;
                        end
                    endcase
                end
                ST_DONE: begin
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                    idx_reg   <= '0;
                    ready_reg <= 1'b1;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                    ready_reg <= 1'b1;
                    done_reg  <= 1'b0;
                    err_reg   <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o         = ready_reg;
    assign done_o          = done_reg;
    assign err_o           = err_reg;
    assign matrix_result_o = result_reg;

endmodule

// File: tb/tb_mat_alu_seq.sv
// Self-checking bench for mat_alu_seq (N=4, W=16) against a behavioural model.
module tb_mat_alu_seq;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int MW = N * N * W;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          start_i = 1'b0;
    logic [3:0]    opcode_i = 4'h0;
    logic [MW-1:0] matrix_a_i = '0;
    logic [MW-1:0] matrix_b_i = '0;
    logic          ready_o;
    logic          done_o;
    logic          err_o;
    logic [MW-1:0] matrix_result_o;

    int            total = 0;
    int            bad = 0;
    logic [MW-1:0] prev_res = '0;

    always #5 clk_i = ~clk_i;

    mat_alu_seq #(.N(N), .W(W)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .start_i         (start_i),
        .opcode_i        (opcode_i),
        .matrix_a_i      (matrix_a_i),
        .matrix_b_i      (matrix_b_i),
        .ready_o         (ready_o),
        .done_o          (done_o),
        .err_o           (err_o),
        .matrix_result_o (matrix_result_o)
    );

    function automatic logic [15:0] el(input logic [MW-1:0] m, input int r, input int c);
        return m[(r*4+c)*16 +: 16];
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < 16; i++) m[i*16 +: 16] = 16'($urandom);
        return m;
    endfunction

    // Reference model straight from the operation definitions.
    function automatic logic [MW-1:0] ref_op(input logic [3:0] op, input logic [MW-1:0] a,
                                             input logic [MW-1:0] b, input logic [MW-1:0] prev,
                                             output logic e);
        logic [MW-1:0] rr;
        longint s;
        rr = '0;
        e  = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                case (op)
                    4'h0: rr[(r*4+c)*16 +: 16] = el(prev, r, c);
                    4'h1: begin
                        s = 0;
                        for (int k = 0; k < 4; k++) s += longint'(el(a, r, k)) * longint'(el(b, k, c));
                        rr[(r*4+c)*16 +: 16] = 16'(s % 65536);
                    end
                    4'h2: rr[(r*4+c)*16 +: 16] = 16'((longint'(el(a, r, c)) * longint'(el(b, 0, 0))) % 65536);
                    4'h3: rr[(r*4+c)*16 +: 16] = 16'((longint'(el(a, r, c)) - longint'(el(b, r, c)) + 65536) % 65536);
                    4'h4: rr[(r*4+c)*16 +: 16] = 16'((longint'(el(a, r, c)) + longint'(el(b, r, c))) % 65536);
                    4'h5: rr[(r*4+c)*16 +: 16] = el(a, c, r);
                    default: begin
                        e = 1'b1;
                        rr[(r*4+c)*16 +: 16] = 16'h0;
                    end
                endcase
            end
        end
        return rr;
    endfunction

    // Issues one operation (called at posedge+1 while idle), scrambles the
    // inputs after acceptance, and returns cycles from accept to done_o
    // (-1 on timeout) plus the observed result/err. Ends one cycle after done.
    task automatic run_op(input logic [3:0] op, input logic [MW-1:0] a, input logic [MW-1:0] b,
                          output int cyc, output logic [MW-1:0] res, output logic e);
        start_i    = 1'b1;
        opcode_i   = op;
        matrix_a_i = a;
        matrix_b_i = b;
        @(posedge clk_i); #1;
        start_i    = 1'b0;
        opcode_i   = 4'($urandom);
        matrix_a_i = rand_mat();
        matrix_b_i = rand_mat();
        cyc = 1;
        while (!done_o && cyc < 40) begin
            @(posedge clk_i); #1;
            cyc++;
        end
        if (!done_o) cyc = -1;
        res = matrix_result_o;
        e   = err_o;
        $display("txn op=%0h cycles=%0d err=%0b result=%h", op, cyc, e, res);
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b want=1", ready_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", done_o); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL reset_err got=%b want=0", err_o); end
        total++; if (matrix_result_o !== '0) begin bad++; $display("FAIL reset_result got=%h want=0", matrix_result_o); end
        prev_res = '0;
    endtask

    task automatic test_mmult();
        logic [MW-1:0] a, b, res, exp_r;
        logic e, exp_e;
        int cyc;
        a = '0;
        for (int r = 0; r < 4; r++) begin
            a[(r*4+r)*16 +: 16] = 16'd1;
            for (int c = 0; c < 4; c++) b[(r*4+c)*16 +: 16] = 16'(r*4+c);
        end
        run_op(4'h1, a, b, cyc, res, e);
        total++; if (cyc !== 17) begin bad++; $display("FAIL mmult_id_latency got=%0d want=17", cyc); end
        total++; if (res !== b) begin bad++; $display("FAIL mmult_id_result got=%h want=%h", res, b); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL mmult_id_err got=%b want=0", e); end
        total++; if (done_o !== 1'b0 || ready_o !== 1'b1) begin bad++; $display("FAIL done_pulse_width done=%b ready=%b want done=0 ready=1", done_o, ready_o); end
        prev_res = b;
        for (int t = 0; t < 3; t++) begin
            a = rand_mat();
            b = rand_mat();
            exp_r = ref_op(4'h1, a, b, prev_res, exp_e);
            run_op(4'h1, a, b, cyc, res, e);
            total++; if (cyc !== 17) begin bad++; $display("FAIL mmult_rand_latency got=%0d want=17", cyc); end
            total++; if (res !== exp_r) begin bad++; $display("FAIL mmult_rand_result got=%h want=%h", res, exp_r); end
            prev_res = exp_r;
        end
    endtask

    task automatic test_add_sub();
        logic [MW-1:0] a, b, res, exp_r;
        logic e, exp_e;
        int cyc;
        for (int i = 0; i < 16; i++) begin
            a[i*16 +: 16] = 16'hFFFF;
            b[i*16 +: 16] = 16'h0002;
            exp_r[i*16 +: 16] = 16'h0001;
        end
        run_op(4'h4, a, b, cyc, res, e);
        total++; if (cyc !== 2) begin bad++; $display("FAIL madd_latency got=%0d want=2", cyc); end
        total++; if (res !== exp_r) begin bad++; $display("FAIL madd_wrap got=%h want=%h", res, exp_r); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL madd_err got=%b want=0", e); end
        for (int i = 0; i < 16; i++) begin
            a[i*16 +: 16] = 16'h0000;
            b[i*16 +: 16] = 16'h0001;
            exp_r[i*16 +: 16] = 16'hFFFF;
        end
        run_op(4'h3, a, b, cyc, res, e);
        total++; if (cyc !== 2) begin bad++; $display("FAIL msub_latency got=%0d want=2", cyc); end
        total++; if (res !== exp_r) begin bad++; $display("FAIL msub_wrap got=%h want=%h", res, exp_r); end
        prev_res = exp_r;
        for (int t = 0; t < 4; t++) begin
            logic [3:0] op;
            op = (t % 2 == 0) ? 4'h4 : 4'h3;
            a = rand_mat();
            b = rand_mat();
            exp_r = ref_op(op, a, b, prev_res, exp_e);
            run_op(op, a, b, cyc, res, e);
            total++; if (res !== exp_r) begin bad++; $display("FAIL addsub_rand op=%0h got=%h want=%h", op, res, exp_r); end
            prev_res = exp_r;
        end
    endtask

    task automatic test_scale();
        logic [MW-1:0] a, b, res, exp_r;
        logic e;
        int cyc;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a[(r*4+c)*16 +: 16]     = 16'(r + c);
                b[(r*4+c)*16 +: 16]     = 16'hDEAD;
                exp_r[(r*4+c)*16 +: 16] = 16'(3 * (r + c));
            end
        end
        b[15:0] = 16'd3;
        run_op(4'h2, a, b, cyc, res, e);
        total++; if (cyc !== 2) begin bad++; $display("FAIL mscale_latency got=%0d want=2", cyc); end
        total++; if (res !== exp_r) begin bad++; $display("FAIL mscale_result got=%h want=%h", res, exp_r); end
        prev_res = exp_r;
    endtask

    task automatic test_trans_bad();
        logic [MW-1:0] a, b, res, exp_r;
        logic e, exp_e;
        int cyc;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                a[(r*4+c)*16 +: 16]     = 16'(r*4 + c);
                exp_r[(r*4+c)*16 +: 16] = 16'(c*4 + r);
            end
        end
        b = rand_mat();
        run_op(4'h5, a, b, cyc, res, e);
        total++; if (cyc !== 2) begin bad++; $display("FAIL mtrans_latency got=%0d want=2", cyc); end
        total++; if (res !== exp_r) begin bad++; $display("FAIL mtrans_result got=%h want=%h", res, exp_r); end
        prev_res = exp_r;
        run_op(4'h9, rand_mat(), rand_mat(), cyc, res, e);
        total++; if (cyc !== 2) begin bad++; $display("FAIL badop_latency got=%0d want=2", cyc); end
        total++; if (e !== 1'b1) begin bad++; $display("FAIL badop_err got=%b want=1", e); end
        total++; if (res !== '0) begin bad++; $display("FAIL badop_result got=%h want=0", res); end
        total++; if (err_o !== 1'b0) begin bad++; $display("FAIL badop_err_clear got=%b want=0", err_o); end
        prev_res = '0;
        // NOP must leave a nonzero result untouched.
        a = rand_mat();
        b = rand_mat();
        exp_r = ref_op(4'h4, a, b, prev_res, exp_e);
        run_op(4'h4, a, b, cyc, res, e);
        prev_res = exp_r;
        run_op(4'h0, rand_mat(), rand_mat(), cyc, res, e);
        total++; if (cyc !== 2) begin bad++; $display("FAIL nop_latency got=%0d want=2", cyc); end
        total++; if (res !== prev_res) begin bad++; $display("FAIL nop_hold got=%h want=%h", res, prev_res); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL nop_err got=%b want=0", e); end
    endtask

    task automatic test_random_ops();
        logic [MW-1:0] a, b, res, exp_r;
        logic [3:0] op;
        logic e, exp_e;
        int cyc;
        for (int t = 0; t < 24; t++) begin
            op = 4'($urandom_range(0, 15));
            a = rand_mat();
            b = rand_mat();
            exp_r = ref_op(op, a, b, prev_res, exp_e);
            run_op(op, a, b, cyc, res, e);
            total++; if (cyc !== ((op == 4'h1) ? 17 : 2)) begin bad++; $display("FAIL rand_latency op=%0h got=%0d", op, cyc); end
            total++; if (res !== exp_r) begin bad++; $display("FAIL rand_result op=%0h got=%h want=%h", op, res, exp_r); end
            total++; if (e !== exp_e) begin bad++; $display("FAIL rand_err op=%0h got=%b want=%b", op, e, exp_e); end
            prev_res = exp_r;
        end
    endtask

    task automatic test_back_to_back();
        logic [MW-1:0] a1, b1, a2, b2, exp1, exp2, r1, r2;
        logic e1, e2, sent;
        int dones, d1, d2, acc, early_ready;
        a1 = rand_mat(); b1 = rand_mat();
        a2 = rand_mat(); b2 = rand_mat();
        exp1 = ref_op(4'h1, a1, b1, prev_res, e1);
        exp2 = ref_op(4'h4, a2, b2, exp1, e2);
        r1 = '0; r2 = '0;
        dones = 0; d1 = -1; d2 = -1; acc = -1; early_ready = 0; sent = 1'b0;
        start_i    = 1'b1;
        opcode_i   = 4'h1;
        matrix_a_i = a1;
        matrix_b_i = b1;
        @(posedge clk_i); #1;
        // start_i stays high with a different operation while MMULT is busy.
        opcode_i   = 4'h4;
        matrix_a_i = a2;
        matrix_b_i = b2;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done_o) begin
                dones++;
                if (dones == 1) begin d1 = cyc; r1 = matrix_result_o; end
                else if (dones == 2) begin d2 = cyc; r2 = matrix_result_o; end
            end
            if (ready_o && dones == 0) early_ready++;
            if (ready_o && dones == 1 && !sent) begin sent = 1'b1; acc = cyc; end
            @(posedge clk_i); #1;
            if (sent) start_i = 1'b0;
        end
        $display("txn back_to_back dones=%0d first=%0d accept=%0d second=%0d", dones, d1, acc, d2);
        total++; if (dones !== 2) begin bad++; $display("FAIL b2b_done_count got=%0d want=2", dones); end
        total++; if (d1 !== 17) begin bad++; $display("FAIL b2b_first_done got=%0d want=17", d1); end
        total++; if (acc !== 18) begin bad++; $display("FAIL b2b_accept got=%0d want=18", acc); end
        total++; if (d2 !== 20) begin bad++; $display("FAIL b2b_second_done got=%0d want=20", d2); end
        total++; if (early_ready !== 0) begin bad++; $display("FAIL b2b_busy_ready got=%0d want=0", early_ready); end
        total++; if (r1 !== exp1) begin bad++; $display("FAIL b2b_first_result got=%h want=%h", r1, exp1); end
        total++; if (r2 !== exp2) begin bad++; $display("FAIL b2b_second_result got=%h want=%h", r2, exp2); end
        prev_res = exp2;
    endtask

    task automatic test_reset_abort();
        logic [MW-1:0] a, b, res, exp_r;
        logic e, exp_e;
        int cyc, stray;
        start_i    = 1'b1;
        opcode_i   = 4'h1;
        matrix_a_i = rand_mat();
        matrix_b_i = rand_mat();
        @(posedge clk_i); #1;
        start_i = 1'b0;
        repeat (4) @(posedge clk_i);
        #1;
        // Now in CALC cycle 5.
        total++; if (ready_o !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", ready_o); end
        rst_i = 1'b1;
        @(posedge clk_i); #1;
        rst_i = 1'b0;
        total++; if (ready_o !== 1'b1) begin bad++; $display("FAIL abort_ready got=%b want=1", ready_o); end
        total++; if (done_o !== 1'b0) begin bad++; $display("FAIL abort_done got=%b want=0", done_o); end
        total++; if (matrix_result_o !== '0) begin bad++; $display("FAIL abort_result got=%h want=0", matrix_result_o); end
        prev_res = '0;
        stray = 0;
        for (int i = 0; i < 20; i++) begin
            if (done_o) stray++;
            @(posedge clk_i); #1;
        end
        $display("txn abort stray_done=%0d", stray);
        total++; if (stray !== 0) begin bad++; $display("FAIL abort_no_done got=%0d want=0", stray); end
        a = rand_mat();
        b = rand_mat();
        exp_r = ref_op(4'h4, a, b, prev_res, exp_e);
        run_op(4'h4, a, b, cyc, res, e);
        total++; if (cyc !== 2) begin bad++; $display("FAIL post_abort_latency got=%0d want=2", cyc); end
        total++; if (res !== exp_r) begin bad++; $display("FAIL post_abort_result got=%h want=%h", res, exp_r); end
        total++; if (e !== 1'b0) begin bad++; $display("FAIL post_abort_err got=%b want=0", e); end
        prev_res = exp_r;
    endtask

    initial begin
        test_reset();
        test_mmult();
        test_add_sub();
        test_scale();
        test_trans_bad();
        test_random_ops();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
